booth_r4_serial_mult: RTL
=========================

# booth_r4_serial_mult

Serial radix-4 Booth multiplier with a start/ready operand handshake, runtime signed/unsigned mode and a backpressured product output. Each cycle it recodes one Booth digit of `y_in`, emits the partial product `digit*x` on an observation stream, and accumulates the full product. It is the next generation of the serial recoder. It adds back-to-back operation, signed operands and a finished result, and sits between the operand source and the product consumer.

## Interface
- `X_WIDTH`, 8: multiplicand width.
- `Y_WIDTH`, 8: multiplier width; digit count N_DIGITS = (Y_WIDTH+2)/2 (integer division).
- `XY_WIDTH`, X_WIDTH+2: partial-product width (derived, not overridden).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  operand valid.
- `in_ready`  out  1  block accepts operands this cycle.
- `signed_mode`  in  1  1 = x and y two's complement, 0 = both unsigned.
- `x_in`  in  X_WIDTH  multiplicand.
- `y_in`  in  Y_WIDTH  multiplier.
- `pp_valid`  out  1  partial product valid (no backpressure).
- `pp`  out  XY_WIDTH  signed partial product digit*x.
- `pp_digit`  out  3  signed Booth digit in {-2..+2}.
- `pp_idx`  out  $clog2(N_DIGITS)  digit index, 0 = least significant.
- `res_valid`  out  1  product valid, held until taken.
- `res_ready`  in  1  consumer accepts product.
- `prod`  out  X_WIDTH+Y_WIDTH  product (signed or unsigned per latched mode).

## Operation
- States: IDLE, RUN, DONE.
- `in_ready` = (IDLE) or (DONE and `res_ready`). Accept = `start` and `in_ready`.
- On accept, the block latches `x_in`, `y_in` and `signed_mode`, clears the accumulator, sets the index to 0 and moves to RUN.
- `start` is ignored whenever `in_ready` is 0.
- Extension: in signed mode, y is sign-extended to 2*N_DIGITS bits and x is sign-extended. In unsigned mode, both are zero-extended. An implicit y[-1] = 0.
- Digit i comes from the triple (y[2i+1], y[2i], y[2i-1]):
  - 000, 111 -> 0
  - 001, 010 -> +1
  - 011 -> +2
  - 100 -> -2
  - 101, 110 -> -1
- RUN, each edge:
  - Register `pp` = digit*x, `pp_digit`, `pp_idx` = i, `pp_valid` = 1.
  - Update accumulator += pp << 2i. The internal width is X_WIDTH+Y_WIDTH+2; `prod` is the low X_WIDTH+Y_WIDTH bits, which is exact for both modes.
- On the edge handling i = N_DIGITS-1, the block registers `prod` as the final sum, sets `res_valid` = 1 and moves to DONE.
- DONE: `prod` and `res_valid` are held stable while `res_ready` = 0.
  - `res_ready` = 1 with no `start` -> IDLE, `res_valid` = 0.
  - `res_ready` = 1 with `start` -> result retires and new operands are accepted on the same edge (RUN).
- `pp_valid` is 0 in every cycle not produced by a RUN edge. The `pp` value is don't-care when `pp_valid` = 0 but is driven to 0.

## Timing
- Reset (`rst` low, asynchronous):
  - State IDLE.
  - `in_ready` = 1.
  - `pp_valid`, `res_valid`, `pp`, `pp_digit`, `pp_idx` and `prod` all 0.
- Reset mid-operation aborts the operation; no partial result appears.
- For an accept at edge k:
  - `pp_valid` is high after edges k+1 … k+N_DIGITS.
  - `res_valid` rises after edge k+N_DIGITS.
- Minimum initiation interval is N_DIGITS+1 cycles when `res_ready` is held high and `start` is asserted in DONE. For X=Y=8 this is 6.
- Operands only need to be valid in the accept cycle.

## Configuration
- `BOOTH_ACC_EN` defined: accumulator and `prod` are built as described.
- `BOOTH_ACC_EN` undefined:
  - The block is a recoder only; there is no accumulator.
  - `prod` is tied to 0.
  - `res_valid` and `res_ready` and the DONE state still operate as an end-of-operation marker with identical timing.

## Test plan
Defaults: X=Y=8, N_DIGITS=5, `res_ready` = 1 unless noted.
- Unsigned x=0x1D, y=0x1B -> digits -1,-1,+2,0,0; pp = -29,-29,58,0,0; `prod` = 0x030F after 5 RUN cycles.
- Unsigned x=0x0A, y=0x0A -> digits -2,-1,+1,0,0; pp = -20,-10,10,0,0; `prod` = 0x0064.
- Signed x=0xFD (-3), y=0xFE (-2) -> digits -2,0,0,0,0; pp = 6,0,0,0,0; `prod` = 0x0006.
  - Signed x=0x80, y=0x80 -> `prod` = 0x4000.
  - Unsigned x=0xFF, y=0xFF -> `prod` = 0xFE01.
- Backpressure: hold `res_ready` = 0 for 5 cycles after `res_valid`.
  - `prod` and `res_valid` are stable, `in_ready` = 0, and a `start` pulse is ignored.
  - Raising `res_ready` with `start` retires the result and accepts new operands on the same edge.
  - The next `pp_valid` follows one cycle later.
- Reset: drop `rst` after the 3rd `pp_valid`.
  - All outputs are 0 immediately and `in_ready` = 1.
  - After release, a new operation (x=0x0A, y=0x0A) yields 0x0064 with normal latency.
- Build without `BOOTH_ACC_EN`, unsigned x=0x1D, y=0x1B:
  - The pp stream is the same as in the first scenario.
  - `prod` = 0 and `res_valid` timing is unchanged.

Source files
------------

// File: rtl/booth_r4_serial_mult.sv
// Serial radix-4 Booth multiplier: one digit per cycle, start/ready in, valid/ready out.
// Define BOOTH_ACC_EN to build the accumulator; otherwise prod is 0 (recoder only).
module booth_r4_serial_mult #(
   parameter  int X_WIDTH  = 8,
   parameter  int Y_WIDTH  = 8,
   localparam int N_DIGITS = (Y_WIDTH + 2) / 2,
   localparam int XY_WIDTH = X_WIDTH + 2,
   localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       in_ready,
   input  logic                       signed_mode,
   input  logic [X_WIDTH-1:0]         x_in,
   input  logic [Y_WIDTH-1:0]         y_in,
   output logic                       pp_valid,
   output logic [XY_WIDTH-1:0]        pp,
   output logic [2:0]                 pp_digit,
   output logic [IDX_W-1:0]           pp_idx,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [X_WIDTH+Y_WIDTH-1:0] prod
);

   localparam int P_WIDTH = X_WIDTH + Y_WIDTH;
   localparam int YE      = 2 * N_DIGITS + 1;
   localparam int YPAD    = 2 * N_DIGITS - Y_WIDTH;
   localparam int XPAD    = XY_WIDTH - X_WIDTH;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e                state_q, state_d;
   logic [XY_WIDTH-1:0]   x_q, x_d;
   logic [YE-1:0]         y_q, y_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  pp_valid_q, pp_valid_d;
   logic [XY_WIDTH-1:0]   pp_q, pp_d;
   logic [2:0]            pp_digit_q, pp_digit_d;
   logic [IDX_W-1:0]      pp_idx_q, pp_idx_d;
   logic                  res_valid_q, res_valid_d;
   logic [2:0]            dig;
   logic [XY_WIDTH-1:0]   ppv;
   logic                  accept;

   // x_q holds the already-extended multiplicand, so mode is folded in at accept
   always_comb begin
      dig = 3'b000;
      ppv = '0;
      unique case (y_q[2:0])
         3'b001, 3'b010: begin
            dig = 3'b001;
            ppv = x_q;
         end
         3'b011: begin
            dig = 3'b010;
            ppv = {x_q[XY_WIDTH-2:0], 1'b0};
         end
         3'b100: begin
            dig = 3'b110;
            ppv = '0 - {x_q[XY_WIDTH-2:0], 1'b0};
         end
         3'b101, 3'b110: begin
            dig = 3'b111;
            ppv = '0 - x_q;
         end
         default: begin
            dig = 3'b000;
            ppv = '0;
         end
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE) ||
                 ((state_q == DONE) && res_ready);
      accept      = start && in_ready;
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      idx_d       = idx_q;
      pp_valid_d  = 1'b0;
      pp_d        = '0;
      pp_digit_d  = '0;
      pp_idx_d    = '0;
      res_valid_d = res_valid_q;
      unique case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         RUN: begin
            pp_valid_d = 1'b1;
            pp_d       = ppv;
            pp_digit_d = dig;
            pp_idx_d   = idx_q;
            y_d        = y_q >> 2;
            idx_d      = idx_q + 1'b1;
            if (idx_q == LAST) begin
               state_d     = DONE;
               res_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (accept) begin
         state_d = RUN;
         x_d     = {{XPAD{signed_mode & x_in[X_WIDTH-1]}}, x_in};
         y_d     = {{YPAD{signed_mode & y_in[Y_WIDTH-1]}},
                    y_in, 1'b0};
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         idx_q       <= '0;
         pp_valid_q  <= 1'b0;
         pp_q        <= '0;
         pp_digit_q  <= '0;
         pp_idx_q    <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         idx_q       <= idx_d;
         pp_valid_q  <= pp_valid_d;
         pp_q        <= pp_d;
         pp_digit_q  <= pp_digit_d;
         pp_idx_q    <= pp_idx_d;
         res_valid_q <= res_valid_d;
      end
   end

`ifdef BOOTH_ACC_EN
   localparam int AW = P_WIDTH + 2;

   logic [AW-1:0]      acc_q, acc_d;
   logic [P_WIDTH-1:0] prod_q, prod_d;
   logic [AW-1:0]      pp_ext;
   logic [AW-1:0]      pp_sh;

   always_comb begin
      pp_ext = {{(AW-XY_WIDTH){ppv[XY_WIDTH-1]}}, ppv};
      pp_sh  = pp_ext << {idx_q, 1'b0};
      acc_d  = acc_q;
      prod_d = prod_q;
      if (state_q == RUN) begin
         acc_d = acc_q + pp_sh;
         if (idx_q == LAST) begin
            prod_d = acc_d[P_WIDTH-1:0];
         end
      end
      if (accept) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '0;
         prod_q <= '0;
      end else begin
         acc_q  <= acc_d;
         prod_q <= prod_d;
      end
   end

   assign prod = prod_q;
`else
   assign prod = '0;
`endif

   assign pp_valid  = pp_valid_q;
   assign pp        = pp_q;
   assign pp_digit  = pp_digit_q;
   assign pp_idx    = pp_idx_q;
   assign res_valid = res_valid_q;

endmodule
